// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: tap/pattern inputs and status outputs of the LFSR pattern checker.
// Latency: wiring only, no storage.
// Backpressure: none; pat_valid qualifies one pattern per cycle and there is no ready.
//
// Ports (by modport):
//   master : drives tap_load, tap_in, pat_valid, pat_in, clr; observes the status outputs.
//   slave  : the checker; observes the inputs, drives locked, mismatch, state,
//            pat_cnt, err_cnt, hd_last, hd_sum.
interface lfsr_checker_if;
    logic        tap_load;
    logic [6:0]  tap_in;
    logic        pat_valid;
    logic [0:7]  pat_in;
    logic        clr;
    logic        locked;
    logic        mismatch;
    logic [1:0]  state;
    logic [15:0] pat_cnt;
    logic [15:0] err_cnt;
    logic [3:0]  hd_last;
    logic [15:0] hd_sum;

    modport master (
        output tap_load, tap_in, pat_valid, pat_in, clr,
        input  locked, mismatch, state, pat_cnt, err_cnt, hd_last, hd_sum
    );

    modport slave (
        input  tap_load, tap_in, pat_valid, pat_in, clr,
        output locked, mismatch, state, pat_cnt, err_cnt, hd_last, hd_sum
    );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto a received 8-stage LFSR pattern stream and counts/grades errors.
// Latency: every status output updates on the edge that consumes the pattern (visible next cycle).
// Backpressure: none; a pattern is consumed on every cycle pat_valid is high, clr drops it.
//
// Ports:
//   clk, rst_n : single rising-edge clock, asynchronous active-low reset.
//   bus        : lfsr_checker_if.slave (tap load, pattern stream, clear, status and counters).
// Parameters: LOCK_CNT matches in SYNC to lock, LOSS_CNT consecutive misses in LOCKED to drop lock.
// Optional: define LFSR_CHK_HD_EN to build the Hamming-distance logic (hd_last/hd_sum);
//           without it both outputs are tied to zero.
module lfsr_checker #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    lfsr_checker_if.slave bus
);
    typedef enum logic [1:0] {
        UNSEEDED = 2'b00,
        SYNC     = 2'b01,
        LOCKED   = 2'b10
    } state_t;

    // run counts 0..LOCK_CNT-1 and miss counts 0..LOSS_CNT-1; the final step is detected
    // against the last value so neither counter needs to hold the terminal count.
    localparam int RUN_W  = (LOCK_CNT < 3) ? 1 : $clog2(LOCK_CNT);
    localparam int MISS_W = (LOSS_CNT < 3) ? 1 : $clog2(LOSS_CNT);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

    state_t            state_q;
    logic [6:0]        tap_q;
    logic [0:7]        exp_q;
    logic [RUN_W-1:0]  run_q;
    logic [MISS_W-1:0] miss_q;
    logic [15:0]       pat_cnt_q;
    logic [15:0]       err_cnt_q;
    logic              mismatch_q;
    logic              locked_q;

    logic [6:0]        tap_eff;
    logic              pat_hit;
    logic [0:7]        nx_exp;
    logic [0:7]        nx_pat;

    // Galois-style step: stage 7 wraps to stage 0 and is XORed into the tapped stages.
    // tap bit 6 feeds stage 1, tap bit 0 feeds stage 7.
    function automatic logic [0:7] nx(input logic [0:7] e, input logic [6:0] t);
        logic [0:7] r;
        r[0] = e[7];
        for (int k = 1; k < 8; k++) begin
            r[3'(k)] = e[3'(k - 1)] ^ (t[3'(7 - k)] & e[7]);
        end
        return r;
    endfunction

    // A tap load on the consuming edge already steers the next-value function,
    // while the compare itself still uses the old EXP.
    always_comb begin
        tap_eff = bus.tap_load ? bus.tap_in : tap_q;
        pat_hit = (bus.pat_in == exp_q);
        nx_exp  = nx(exp_q, tap_eff);
        nx_pat  = nx(bus.pat_in, tap_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNSEEDED;
            tap_q      <= '0;
            exp_q      <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            pat_cnt_q  <= '0;
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
        end else if (bus.clr) begin
            // Clear wins over a pattern in the same cycle; taps survive (and may still load).
            if (bus.tap_load) begin
                tap_q <= bus.tap_in;
            end
            state_q    <= UNSEEDED;
            run_q      <= '0;
            miss_q     <= '0;
            pat_cnt_q  <= '0;
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            if (bus.tap_load) begin
                tap_q <= bus.tap_in;
            end
            mismatch_q <= 1'b0;

            if (bus.pat_valid) begin
                if (pat_cnt_q != 16'hFFFF) begin
                    pat_cnt_q <= pat_cnt_q + 16'd1;
                end

                case (state_q)
                    UNSEEDED: begin
                        // First pattern is trusted as the seed; nothing to compare against.
                        exp_q    <= nx_pat;
                        run_q    <= '0;
                        miss_q   <= '0;
                        state_q  <= SYNC;
                        locked_q <= 1'b0;
                    end
                    SYNC: begin
                        if (pat_hit) begin
                            exp_q <= nx_exp;
                            if (run_q == RUN_LAST) begin
                                run_q    <= '0;
                                miss_q   <= '0;
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                run_q <= run_q + 1'b1;
                            end
                        end else begin
                            // Not yet trusted: resynchronise on the received pattern.
                            exp_q      <= nx_pat;
                            run_q      <= '0;
                            mismatch_q <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        // Once locked, the local generator free-runs so bit errors are not
                        // copied into EXP.
                        exp_q <= nx_exp;
                        if (pat_hit) begin
                            miss_q <= '0;
                        end else begin
                            mismatch_q <= 1'b1;
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_q <= err_cnt_q + 16'd1;
                            end
                            if (miss_q == MISS_LAST) begin
                                miss_q   <= '0;
                                state_q  <= UNSEEDED;
                                locked_q <= 1'b0;
                            end else begin
                                miss_q <= miss_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q  <= UNSEEDED;
                        locked_q <= 1'b0;
                    end
                endcase

                // New taps invalidate any established sequence; overrides the case above.
                if (bus.tap_load && (state_q != UNSEEDED)) begin
                    state_q  <= UNSEEDED;
                    locked_q <= 1'b0;
                end
            end else if (bus.tap_load && (state_q != UNSEEDED)) begin
                state_q  <= UNSEEDED;
                locked_q <= 1'b0;
            end
        end
    end

    assign bus.state    = state_q;
    assign bus.locked   = locked_q;
    assign bus.mismatch = mismatch_q;
    assign bus.pat_cnt  = pat_cnt_q;
    assign bus.err_cnt  = err_cnt_q;

`ifdef LFSR_CHK_HD_EN
    logic [3:0]  hd_cur;
    logic [16:0] hd_sum_add;
    logic [3:0]  hd_last_q;
    logic [15:0] hd_sum_q;

    always_comb begin
        hd_cur = 4'd0;
        for (int i = 0; i < 8; i++) begin
            hd_cur = hd_cur + {3'd0, bus.pat_in[i] ^ exp_q[i]};
        end
        hd_sum_add = {1'b0, hd_sum_q} + {13'd0, hd_cur};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_last_q <= '0;
            hd_sum_q  <= '0;
        end else if (bus.clr) begin
            hd_last_q <= '0;
            hd_sum_q  <= '0;
        end else if (bus.pat_valid) begin
            // A seed has no expected value, so its distance is reported as zero.
            hd_last_q <= (state_q == UNSEEDED) ? 4'd0 : hd_cur;
            if ((state_q == LOCKED) && !pat_hit) begin
                hd_sum_q <= hd_sum_add[16] ? 16'hFFFF : hd_sum_add[15:0];
            end
        end
    end

    assign bus.hd_last = hd_last_q;
    assign bus.hd_sum  = hd_sum_q;
`else
    assign bus.hd_last = '0;
    assign bus.hd_sum  = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker (reference model predicts every cycle).
// Latency: expected values are pushed when stimulus is driven, popped one edge later.
// Backpressure: n/a.
module tb_lfsr_checker;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
`ifdef LFSR_CHK_HD_EN
    localparam bit HD_ON = 1'b1;
`else
    localparam bit HD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  state;
        logic        locked;
        logic        mismatch;
        logic [15:0] pat_cnt;
        logic [15:0] err_cnt;
        logic [3:0]  hd_last;
        logic [15:0] hd_sum;
    } obs_t;

    logic clk;
    logic rst_n;
    lfsr_checker_if bus ();

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    obs_t sb[$];

    // Reference model state
    logic [1:0]  m_state;
    logic [6:0]  m_tap;
    logic [0:7]  m_exp;
    int          m_run;
    int          m_miss;
    logic [15:0] m_pcnt;
    logic [15:0] m_ecnt;
    logic [15:0] m_hds;
    logic [3:0]  m_hdl;
    logic        m_mis;

    // Shift toward stage 7, then fold the wrapped bit into the tapped stages.
    function automatic logic [0:7] ref_nx(input logic [0:7] e, input logic [6:0] t);
        logic [0:7] r;
        logic       fb;
        fb = e[7];
        r  = {fb, e[0:6]};
        if (fb) r[1:7] = r[1:7] ^ t;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.state    = bus.state;
        o.locked   = bus.locked;
        o.mismatch = bus.mismatch;
        o.pat_cnt  = bus.pat_cnt;
        o.err_cnt  = bus.err_cnt;
        o.hd_last  = bus.hd_last;
        o.hd_sum   = bus.hd_sum;
        return o;
    endfunction

    task automatic model_reset();
        m_state = 2'b00; m_tap = '0; m_exp = '0; m_run = 0; m_miss = 0;
        m_pcnt = '0; m_ecnt = '0; m_hds = '0; m_hdl = '0; m_mis = 1'b0;
        sb.delete();
    endtask

    task automatic model_step(input logic tl, input logic [6:0] ti, input logic pv,
                              input logic [0:7] pi, input logic c);
        logic [6:0] tnew;
        logic [1:0] old_state;
        logic       hit;
        int         hd;
        obs_t       e;
        tnew      = tl ? ti : m_tap;
        old_state = m_state;
        m_mis     = 1'b0;
        if (c) begin
            m_state = 2'b00; m_run = 0; m_miss = 0;
            m_pcnt = '0; m_ecnt = '0; m_hds = '0; m_hdl = '0;
        end else if (pv) begin
            hit = (pi == m_exp);
            hd  = $countones(pi ^ m_exp);
            if (m_pcnt != 16'hFFFF) m_pcnt = m_pcnt + 16'd1;
            if (old_state == 2'b00) begin
                m_exp = ref_nx(pi, tnew); m_run = 0; m_miss = 0; m_state = 2'b01; m_hdl = '0;
            end else begin
                m_hdl = HD_ON ? 4'(hd) : 4'd0;
                if (old_state == 2'b01) begin
                    if (hit) begin
                        m_exp = ref_nx(m_exp, tnew);
                        m_run++;
                        if (m_run == LOCK_CNT) begin m_state = 2'b10; m_run = 0; m_miss = 0; end
                    end else begin
                        m_exp = ref_nx(pi, tnew); m_run = 0; m_mis = 1'b1;
                    end
                end else begin
                    m_exp = ref_nx(m_exp, tnew);
                    if (hit) m_miss = 0;
                    else begin
                        m_mis = 1'b1;
                        if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
                        if (HD_ON) m_hds = (int'(m_hds) + hd > 65535) ? 16'hFFFF : m_hds + 16'(hd);
                        m_miss++;
                        if (m_miss == LOSS_CNT) begin m_state = 2'b00; m_miss = 0; end
                    end
                end
            end
        end
        if (!c && tl && old_state != 2'b00) m_state = 2'b00;
        m_tap = tnew;
        e.state = m_state; e.locked = (m_state == 2'b10); e.mismatch = m_mis;
        e.pat_cnt = m_pcnt; e.err_cnt = m_ecnt; e.hd_last = m_hdl; e.hd_sum = m_hds;
        sb.push_back(e);
    endtask

    task automatic drive(input logic tl, input logic [6:0] ti, input logic pv,
                         input logic [0:7] pi, input logic c);
        bus.tap_load = tl; bus.tap_in = ti; bus.pat_valid = pv; bus.pat_in = pi; bus.clr = c;
        model_step(tl, ti, pv, pi, c);
        @(posedge clk);
        #1;
        bus.tap_load = 1'b0; bus.pat_valid = 1'b0; bus.clr = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        got = observe();
        total++;
        if (got !== obs_t'(0)) begin bad++; $display("FAIL reset_state got=%h exp=0", got); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        logic [0:7] pats [4] = '{8'b1000_0000, 8'b0100_0000, 8'b0010_0000, 8'b0001_0000};
        logic [1:0] st   [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        obs_t got, e;
        drive(1'b1, 7'b0011101, 1'b0, 8'h00, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL lock_tapload got=%h exp=%h", got, e); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7'd0, 1'b1, pats[i], 1'b0);
            got = observe(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL lock_sb%0d got=%h exp=%h", i, got, e); end
            total++;
            if (bus.state !== st[i]) begin bad++; $display("FAIL lock_state%0d got=%b exp=%b", i, bus.state, st[i]); end
        end
        total++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd0) begin
            bad++; $display("FAIL lock_final locked=%b err=%0d exp locked=1 err=0", bus.locked, bus.err_cnt);
        end
    endtask

    task automatic test_mismatch();
        logic [0:7] seeds [4] = '{8'b0000_0100, 8'b0000_0010, 8'b0000_0001, 8'b1000_0000};
        logic [3:0] hd_req;
        obs_t got, e;
        hd_req = HD_ON ? 4'd2 : 4'd0;
        drive(1'b0, 7'd0, 1'b0, 8'h00, 1'b1);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mm_clr got=%h exp=%h", got, e); end
        drive(1'b1, 7'd0, 1'b0, 8'h00, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mm_tap got=%h exp=%h", got, e); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 7'd0, 1'b1, seeds[i], 1'b0);
            got = observe(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL mm_seed%0d got=%h exp=%h", i, got, e); end
        end
        // EXP is now 0100_0000; two bits flipped
        drive(1'b0, 7'd0, 1'b1, 8'b0100_0011, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mm_err got=%h exp=%h", got, e); end
        total++;
        if (bus.mismatch !== 1'b1 || bus.err_cnt !== 16'd1 || bus.hd_last !== hd_req ||
            bus.hd_sum !== {12'd0, hd_req} || bus.locked !== 1'b1) begin
            bad++;
            $display("FAIL mm_vector mis=%b err=%0d hd=%0d sum=%0d lk=%b exp mis=1 err=1 hd=%0d sum=%0d lk=1",
                     bus.mismatch, bus.err_cnt, bus.hd_last, bus.hd_sum, bus.locked, hd_req, hd_req);
        end
        drive(1'b0, 7'd0, 1'b0, 8'hFF, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mm_idle got=%h exp=%h", got, e); end
        total++;
        if (bus.mismatch !== 1'b0 || bus.err_cnt !== 16'd1) begin
            bad++; $display("FAIL mm_hold mis=%b err=%0d exp mis=0 err=1", bus.mismatch, bus.err_cnt);
        end
        // A good pattern clears the miss run, so a later single error keeps lock.
        drive(1'b0, 7'd0, 1'b1, m_exp, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mm_good got=%h exp=%h", got, e); end
        drive(1'b0, 7'd0, 1'b1, m_exp ^ 8'h01, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mm_err2 got=%h exp=%h", got, e); end
        total++;
        if (bus.locked !== 1'b1 || bus.err_cnt !== 16'd2) begin
            bad++; $display("FAIL mm_keep locked=%b err=%0d exp locked=1 err=2", bus.locked, bus.err_cnt);
        end
        drive(1'b0, 7'd0, 1'b1, m_exp, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL mm_good2 got=%h exp=%h", got, e); end
    endtask

    task automatic test_loss();
        obs_t got, e;
        drive(1'b0, 7'd0, 1'b1, m_exp ^ 8'h81, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL loss_1 got=%h exp=%h", got, e); end
        drive(1'b0, 7'd0, 1'b1, m_exp ^ 8'h10, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL loss_2 got=%h exp=%h", got, e); end
        total++;
        if (bus.state !== 2'b00 || bus.locked !== 1'b0) begin
            bad++; $display("FAIL loss_state state=%b locked=%b exp state=00 locked=0", bus.state, bus.locked);
        end
        drive(1'b0, 7'd0, 1'b1, m_exp, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL loss_reseed got=%h exp=%h", got, e); end
        total++;
        if (bus.state !== 2'b01 || bus.mismatch !== 1'b0) begin
            bad++; $display("FAIL loss_sync state=%b mis=%b exp state=01 mis=0", bus.state, bus.mismatch);
        end
    endtask

    task automatic test_clr();
        obs_t got, e;
        drive(1'b0, 7'd0, 1'b1, 8'hA5, 1'b1);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL clr_sb got=%h exp=%h", got, e); end
        total++;
        if (bus.pat_cnt !== 16'd0 || bus.err_cnt !== 16'd0 || bus.hd_sum !== 16'd0 ||
            bus.hd_last !== 4'd0 || bus.state !== 2'b00 || bus.mismatch !== 1'b0) begin
            bad++; $display("FAIL clr_zero pcnt=%0d err=%0d sum=%0d hd=%0d state=%b exp all 0",
                            bus.pat_cnt, bus.err_cnt, bus.hd_sum, bus.hd_last, bus.state);
        end
        drive(1'b0, 7'd0, 1'b1, 8'h3C, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL clr_next got=%h exp=%h", got, e); end
        total++;
        if (bus.pat_cnt !== 16'd1 || bus.state !== 2'b01) begin
            bad++; $display("FAIL clr_seed pcnt=%0d state=%b exp pcnt=1 state=01", bus.pat_cnt, bus.state);
        end
    endtask

    task automatic test_tap_load();
        obs_t got, e;
        for (int i = 0; i < LOCK_CNT; i++) begin
            drive(1'b0, 7'd0, 1'b1, m_exp, 1'b0);
            got = observe(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL tl_lock%0d got=%h exp=%h", i, got, e); end
        end
        // New taps with a matching pattern: compare uses old EXP, block unseeds.
        drive(1'b1, 7'b1100011, 1'b1, m_exp, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL tl_load got=%h exp=%h", got, e); end
        total++;
        if (bus.mismatch !== 1'b0 || bus.state !== 2'b00 || bus.locked !== 1'b0) begin
            bad++; $display("FAIL tl_unseed mis=%b state=%b lk=%b exp mis=0 state=00 lk=0",
                            bus.mismatch, bus.state, bus.locked);
        end
        // Seed and tap load on the same edge: the seed must advance with the new taps.
        drive(1'b1, 7'b1010101, 1'b1, 8'b0000_0001, 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL tl_seed got=%h exp=%h", got, e); end
        drive(1'b0, 7'd0, 1'b1, ref_nx(8'b0000_0001, 7'b1010101), 1'b0);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL tl_newtap got=%h exp=%h", got, e); end
        total++;
        if (bus.mismatch !== 1'b0 || bus.state !== 2'b01) begin
            bad++; $display("FAIL tl_newtap_match mis=%b state=%b exp mis=0 state=01", bus.mismatch, bus.state);
        end
    endtask

    task automatic test_zero_seed();
        obs_t got, e;
        drive(1'b0, 7'd0, 1'b0, 8'h00, 1'b1);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL zero_clr got=%h exp=%h", got, e); end
        for (int i = 0; i <= LOCK_CNT; i++) begin
            drive(1'b0, 7'd0, 1'b1, 8'h00, 1'b0);
            got = observe(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL zero_%0d got=%h exp=%h", i, got, e); end
        end
        total++;
        if (bus.locked !== 1'b1 || bus.mismatch !== 1'b0) begin
            bad++; $display("FAIL zero_lock locked=%b mis=%b exp locked=1 mis=0", bus.locked, bus.mismatch);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        for (int i = 0; i < 400; i++) begin
            logic       tl, pv, c;
            logic [6:0] ti;
            logic [0:7] pi;
            tl = ($urandom_range(0, 49) == 0);
            ti = 7'($urandom);
            pv = ($urandom_range(0, 9) < 8);
            c  = ($urandom_range(0, 149) == 0);
            pi = ($urandom_range(0, 9) < 9) ? m_exp : 8'($urandom);
            drive(tl, ti, pv, pi, c);
            got = observe(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_async_reset();
        obs_t got, e;
        drive(1'b1, 7'b0011101, 1'b1, 8'h96, 1'b1);
        got = observe(); e = sb.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL ar_clr got=%h exp=%h", got, e); end
        for (int i = 0; i <= LOCK_CNT; i++) begin
            drive(1'b0, 7'd0, 1'b1, (i == 0) ? 8'hC3 : m_exp, 1'b0);
            got = observe(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL ar_lock%0d got=%h exp=%h", i, got, e); end
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (bus.state !== 2'b00 || bus.locked !== 1'b0 || bus.pat_cnt !== 16'd0 ||
            bus.err_cnt !== 16'd0 || bus.mismatch !== 1'b0 || bus.hd_last !== 4'd0) begin
            bad++; $display("FAIL ar_immediate state=%b lk=%b pcnt=%0d err=%0d exp all 0",
                            bus.state, bus.locked, bus.pat_cnt, bus.err_cnt);
        end
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i <= LOCK_CNT; i++) begin
            drive(1'b0, 7'd0, 1'b1, (i == 0) ? 8'h5A : m_exp, 1'b0);
            got = observe(); e = sb.pop_front(); total++;
            if (got !== e) begin bad++; $display("FAIL ar_relock%0d got=%h exp=%h", i, got, e); end
            total++;
            if (bus.locked !== (i == LOCK_CNT)) begin
                bad++; $display("FAIL ar_count%0d locked=%b exp=%b", i, bus.locked, (i == LOCK_CNT));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.tap_load = 1'b0; bus.tap_in = '0; bus.pat_valid = 1'b0; bus.pat_in = '0; bus.clr = 1'b0;
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_lock();
        test_mismatch();
        test_loss();
        test_clr();
        test_tap_load();
        test_zero_seed();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_CNT, default 3: consecutive matching patterns needed to enter LOCKED.
REQ-002 Parameter LOSS_CNT, default 2: consecutive mismatches in LOCKED that return the block to UNSEEDED.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tap_load  input  1  when 1, captures tap_in into the tap register.
REQ-006 tap_in  input  7  feedback taps; tap_in[6] drives stage 1 and tap_in[0] drives stage 7.
REQ-007 pat_valid  input  1  qualifies pat_in; one pattern is consumed per cycle while pat_valid is high.
REQ-008 pat_in  input  8 ([0:7])  received LFSR pattern, stage 0 first.
REQ-009 clr  input  1  synchronous clear of the counters and the state machine; taps are kept.
REQ-010 locked  output  1  high in the LOCKED state.
REQ-011 mismatch  output  1  one-cycle pulse: the consumed pattern was not equal to the expected pattern.
REQ-012 state  output  2  00 UNSEEDED, 01 SYNC, 10 LOCKED.
REQ-013 pat_cnt  output  16  count of consumed patterns; saturates at 16'hFFFF.
REQ-014 err_cnt  output  16  count of mismatches while LOCKED; saturates.
REQ-015 hd_last  output  4  Hamming distance (0-8) between the last consumed pattern and its expected value.
REQ-016 hd_sum  output  16  saturating sum of hd_last over mismatches taken in LOCKED.

Function
REQ-017 The next-value function nx(E) SHALL be: nx[0]=E[7]; nx[k]=E[k-1] XOR (tap[7-k] AND E[7]) for k=1..7.
REQ-018 Expected register EXP: on each consumed pattern, EXP <= nx(EXP) in SYNC/LOCKED, or nx(pat_in) when (re)seeding.
REQ-019 Compare: pattern matches when pat_in == EXP; hd_last = popcount(pat_in XOR EXP), registered one cycle after consumption.
REQ-020 UNSEEDED: the first consumed pattern seeds EXP=nx(pat_in), run=0, moves to SYNC; mismatch stays 0 and err_cnt is unchanged.
REQ-021 SYNC: a match increments run; run reaching LOCK_CNT moves to LOCKED, with locked high the next cycle. A mismatch reseeds from pat_in and sets run=0, with no err_cnt increment.
REQ-022 LOCKED: a match clears the miss counter. A mismatch increments err_cnt, adds hd_last to hd_sum and increments miss; EXP still advances from EXP, not from pat_in.
REQ-023 When miss reaches LOSS_CNT, the block moves to UNSEEDED; the next consumed pattern reseeds.
REQ-024 mismatch, hd_last and counter updates SHALL appear exactly one cycle after the consuming edge.
REQ-025 When pat_valid is 0, the state, EXP, run, miss and all outputs hold; mismatch is 0.
REQ-026 tap_load SHALL take effect on the same edge as a simultaneous consumed pattern's compare: the compare uses the old EXP, and nx uses the new taps.
REQ-027 tap_load in LOCKED or SYNC forces UNSEEDED; counters are kept.
REQ-028 clr has priority over pat_valid: it returns to UNSEEDED and zeroes pat_cnt, err_cnt, hd_sum, hd_last, run and miss. A pattern presented in the same cycle is dropped.
REQ-029 Saturating counters SHALL not wrap; hd_sum clamps at 16'hFFFF.
REQ-030 Pattern 8'h00 with any taps is a legal seed; the all-zero sequence locks normally.

Reset
REQ-031 rst_n low SHALL force, immediately: state UNSEEDED, taps 0, EXP 0, all counters 0, locked 0, mismatch 0, hd_last 0.
REQ-032 Reset asserted mid-sequence SHALL discard lock; after release, the first consumed pattern reseeds.

Configuration
REQ-033 Macro LFSR_CHK_HD_EN defined: hd_last and hd_sum operate per REQ-019/022.
REQ-034 Macro LFSR_CHK_HD_EN undefined: the popcount and hd_sum logic are removed, and hd_last/hd_sum are tied to 0; all other behaviour is unchanged.

Verification
REQ-035 Taps 7'b0011101, patterns 8'b1000_0000, 8'b0100_0000, 8'b0010_0000, 8'b0001_0000 -> state SYNC then LOCKED after the 4th; err_cnt 0.
REQ-036 LOCKED, EXP 8'b0100_0000, send 8'b0100_0011 -> mismatch pulse, err_cnt +1, hd_last 2, hd_sum +2, still locked.
REQ-037 LOCKED, two consecutive corrupted patterns -> state 00 and locked 0; the next good pattern reseeds to SYNC.
REQ-038 clr and pat_valid asserted in the same cycle -> all counters 0, pattern ignored, state 00.
REQ-039 rst_n pulsed low mid-LOCKED, asynchronously to clk -> outputs 0 before the next edge; relock needs 1+LOCK_CNT patterns.
REQ-040 Build without LFSR_CHK_HD_EN, repeat REQ-036 -> err_cnt +1, hd_last 0, hd_sum 0.
